lap_countdown_timer: RTL and testbench

//  Parametrised stopwatch/countdown core; successor to the single-mode watch timer.
//  Two modes: stopwatch (count up, lap freeze) and countdown (count down from a preset, ring at zero).

---
 rtl/lap_countdown_timer_pkg.sv | 6 +
 rtl/lap_countdown_timer_if.sv | 19 +
 rtl/lap_countdown_timer_tick_divider.sv | 16 +
 rtl/lap_countdown_timer.sv | 103 ++++++++++
 tb/tb_lap_countdown_timer.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/lap_countdown_timer_pkg.sv
// lap_countdown_timer_pkg: shared FSM state encoding and mode constants.
package lap_countdown_timer_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, RING = 2'd3} state_t;
    localparam logic MODE_SW = 1'b0;
    localparam logic MODE_CD = 1'b1;
endpackage

// File: rtl/lap_countdown_timer_if.sv
// lap_countdown_timer_if: front-panel buttons, preset and display/alarm outputs.
interface lap_countdown_timer_if #(parameter int CNT_W = 32);
    logic             modeInput;
    logic             startOrStop;
    logic             splitOrReset;
    logic [CNT_W-1:0] presetValue;
    logic             presetLoad;
    logic             mode;
    logic             running;
    logic [CNT_W-1:0] countValue;
    logic [CNT_W-1:0] lapValue;
    logic             lapHeld;
    logic             ringSound;
    logic             overflow;
    modport master (output modeInput, startOrStop, splitOrReset, presetValue, presetLoad,
                    input  mode, running, countValue, lapValue, lapHeld, ringSound, overflow);
    modport slave  (input  modeInput, startOrStop, splitOrReset, presetValue, presetLoad,
                    output mode, running, countValue, lapValue, lapHeld, ringSound, overflow);
endinterface

// File: rtl/lap_countdown_timer_tick_divider.sv
// lap_countdown_timer_tick_divider: one-cycle tick every DIV clocks, restartable by clr.
module lap_countdown_timer_tick_divider #(
    parameter int DIV = 10
) (
    input  logic clockSignal,
    input  logic resetSignal,
    input  logic clr,
    output logic tick
);
    localparam int W = DIV > 1 ? $clog2(DIV) : 1;
    logic [W-1:0] cnt;
    assign tick = cnt == W'(DIV - 1);
    always_ff @(posedge clockSignal or posedge resetSignal)
        if (resetSignal) cnt <= '0;
        else cnt <= (clr || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/lap_countdown_timer.sv
// lap_countdown_timer: stopwatch with lap freeze and countdown with alarm.
module lap_countdown_timer
    import lap_countdown_timer_pkg::*;
#(
    parameter int CLK_HZ  = 100,
    parameter int TICK_HZ = 100,
    parameter int CNT_W   = 32
) (
    input  logic clockSignal,
    input  logic resetSignal,
    lap_countdown_timer_if.slave bus
);
    state_t           state;
    logic             mode_r, running, lap_held, ring, ovf, tick;
    logic [CNT_W-1:0] count, lap, preset, pnext;
    logic [2:0]       btn, prev;
    logic             se, pe, me, expired;
    assign btn     = {bus.modeInput, bus.splitOrReset, bus.startOrStop};
    assign se      = btn[0] & ~prev[0];
    assign pe      = btn[1] & ~prev[1] & ~se;
    assign me      = btn[2] & ~prev[2] & ~se & ~pe;
    assign pnext   = bus.presetLoad ? bus.presetValue : preset;
    assign expired = mode_r && count == '0;
    lap_countdown_timer_tick_divider #(.DIV(CLK_HZ / TICK_HZ)) u_div (
        .clockSignal(clockSignal),
        .resetSignal(resetSignal),
        .clr        (se),
        .tick       (tick)
    );
    always_ff @(posedge clockSignal or posedge resetSignal)
        if (resetSignal) begin
            state    <= IDLE;
            mode_r   <= MODE_SW;
            running  <= 1'b0;
            lap_held <= 1'b0;
            ring     <= 1'b0;
            ovf      <= 1'b0;
            count    <= '0;
            lap      <= '0;
            preset   <= '0;
            prev     <= '0;
        end else begin
            prev   <= btn;
            preset <= pnext;
            if (bus.presetLoad && mode_r == MODE_CD && (state == IDLE || state == PAUSE))
                count <= bus.presetValue;
            case (state)
                IDLE, PAUSE: begin
                    if (se) begin
                        state   <= expired ? RING : RUN;
                        running <= !expired;
                        ring    <= expired;
                    end else if (pe && state == IDLE) begin
                        count <= '0;
                        lap   <= '0;
                        ovf   <= 1'b0;
                    end else if (pe) begin
                        state    <= IDLE;
                        count    <= mode_r ? pnext : '0;
                        lap_held <= 1'b0;
                    end else if (me && state == IDLE) begin
                        mode_r <= ~mode_r;
                        count  <= mode_r ? '0 : pnext;
                    end
                end
                RUN: begin
                    if (se) begin
                        state   <= PAUSE;
                        running <= 1'b0;
                    end else if (expired) begin
                        state   <= RING;
                        running <= 1'b0;
                        ring    <= 1'b1;
                    end else begin
                        if (pe) begin
                            lap_held <= ~lap_held;
                            if (!lap_held) lap <= count;
                        end
                        // stopwatch saturates at all-ones instead of wrapping
                        if (tick) begin
                            count <= mode_r ? count - 1'b1 : (&count ? count : count + 1'b1);
                            ovf   <= ovf | (~mode_r & (&count));
                        end
                    end
                end
                RING: begin
                    if (se) begin
                        state <= IDLE;
                        ring  <= 1'b0;
                        count <= pnext;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    assign bus.mode       = mode_r;
    assign bus.running    = running;
    assign bus.countValue = count;
    assign bus.lapValue   = lap_held ? lap : count;
    assign bus.lapHeld    = lap_held;
    assign bus.ringSound  = ring;
    assign bus.overflow   = ovf;
endmodule

// File: tb/tb_lap_countdown_timer.sv
// tb_lap_countdown_timer: directed checks of stopwatch, lap, countdown, saturation and reset.
module tb_lap_countdown_timer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    lap_countdown_timer_if #(.CNT_W(8)) bus();
    lap_countdown_timer #(.CLK_HZ(10), .TICK_HZ(1), .CNT_W(8)) dut (
        .clockSignal(clk),
        .resetSignal(rst),
        .bus        (bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask
    // mask bits: [0] start, [1] split, [2] mode; returns with buttons low for a cycle
    task automatic press(input logic [2:0] m);
        bus.startOrStop  = m[0];
        bus.splitOrReset = m[1];
        bus.modeInput    = m[2];
        @(negedge clk);
        bus.startOrStop  = 1'b0;
        bus.splitOrReset = 1'b0;
        bus.modeInput    = 1'b0;
        @(negedge clk);
    endtask
    task automatic load(input logic [7:0] v);
        bus.presetValue = v;
        bus.presetLoad  = 1'b1;
        @(negedge clk);
        bus.presetLoad  = 1'b0;
    endtask
    initial begin
        bus.startOrStop  = 1'b0;
        bus.splitOrReset = 1'b0;
        bus.modeInput    = 1'b0;
        bus.presetValue  = 8'd0;
        bus.presetLoad   = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(1);
        chk("rst_count", int'(bus.countValue), 0);
        chk("rst_running", int'(bus.running), 0);
        chk("rst_mode", int'(bus.mode), 0);
        chk("rst_ring", int'(bus.ringSound), 0);
        chk("rst_ovf", int'(bus.overflow), 0);
        chk("rst_lap", int'(bus.lapHeld), 0);
        press(3'b001);
        chk("sw_running", int'(bus.running), 1);
        chk("sw_count0", int'(bus.countValue), 0);
        cyc(34);
        chk("sw_count3", int'(bus.countValue), 3);
        press(3'b001);
        chk("sw_pause", int'(bus.running), 0);
        cyc(10);
        chk("sw_hold", int'(bus.countValue), 3);
        press(3'b010);
        chk("sw_clear", int'(bus.countValue), 0);
        press(3'b001);
        cyc(23);
        chk("lap_c2", int'(bus.countValue), 2);
        press(3'b010);
        chk("lap_held", int'(bus.lapHeld), 1);
        chk("lap_val2", int'(bus.lapValue), 2);
        cyc(29);
        chk("lap_c5", int'(bus.countValue), 5);
        chk("lap_frozen", int'(bus.lapValue), 2);
        press(3'b010);
        chk("lap_rel", int'(bus.lapHeld), 0);
        chk("lap_track", int'(bus.lapValue), 5);
        press(3'b001);
        press(3'b010);
        chk("lap_clr", int'(bus.countValue), 0);
        press(3'b100);
        chk("cd_mode", int'(bus.mode), 1);
        load(8'd3);
        chk("cd_load", int'(bus.countValue), 3);
        press(3'b001);
        chk("cd_run", int'(bus.running), 1);
        cyc(8);
        chk("cd_pre_tick", int'(bus.countValue), 3);
        cyc(1);
        chk("cd_c2", int'(bus.countValue), 2);
        cyc(10);
        chk("cd_c1", int'(bus.countValue), 1);
        cyc(10);
        chk("cd_c0", int'(bus.countValue), 0);
        chk("cd_ring_late", int'(bus.ringSound), 0);
        cyc(1);
        chk("cd_ring", int'(bus.ringSound), 1);
        chk("cd_ring_run", int'(bus.running), 0);
        press(3'b001);
        chk("cd_dismiss", int'(bus.ringSound), 0);
        chk("cd_reload", int'(bus.countValue), 3);
        load(8'd0);
        press(3'b001);
        chk("cd0_ring", int'(bus.ringSound), 1);
        press(3'b001);
        chk("cd0_dismiss", int'(bus.ringSound), 0);
        load(8'd5);
        press(3'b001);
        press(3'b100);
        chk("cd_mode_run", int'(bus.mode), 1);
        press(3'b001);
        press(3'b010);
        chk("cd_pause_idle", int'(bus.countValue), 5);
        press(3'b100);
        chk("sw_mode", int'(bus.mode), 0);
        chk("sw_mode_cnt", int'(bus.countValue), 0);
        press(3'b001);
        cyc(2544);
        chk("sat_254", int'(bus.countValue), 254);
        chk("sat_ovf0", int'(bus.overflow), 0);
        cyc(10);
        chk("sat_255", int'(bus.countValue), 255);
        cyc(10);
        chk("sat_hold", int'(bus.countValue), 255);
        chk("sat_ovf", int'(bus.overflow), 1);
        chk("sat_run", int'(bus.running), 1);
        press(3'b011);
        chk("prio_pause", int'(bus.running), 0);
        chk("prio_nolap", int'(bus.lapHeld), 0);
        chk("prio_cnt", int'(bus.countValue), 255);
        press(3'b011);
        chk("prio_resume", int'(bus.running), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_count", int'(bus.countValue), 0);
        chk("arst_running", int'(bus.running), 0);
        chk("arst_ovf", int'(bus.overflow), 0);
        @(negedge clk);
        rst = 1'b0;
        cyc(12);
        chk("arst_idle", int'(bus.running), 0);
        chk("arst_idle_cnt", int'(bus.countValue), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
